// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart transmit arbiter.
// State encoding, tag base character and grant-index width helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAG  = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3
    } state_t;

    localparam logic [7:0] TAG_BASE = 8'h30;

    // Index width for n clients; a single client still gets one bit.
    function automatic int grant_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: lowest valid index at or after ptr, else the lowest
// valid index overall (wrap).
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] upper_s;
    logic [W-1:0] upper_idx_s;
    logic [W-1:0] any_idx_s;

    // Masked and unmasked priority searches, lowest index wins in each
    always_comb begin
        upper_s     = {N{1'b0}};
        upper_idx_s = {W{1'b0}};
        any_idx_s   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            upper_s[i] = valid[i] & (i >= int'(ptr));
        end
        for (int i = N - 1; i >= 0; i--) begin
            upper_idx_s = upper_s[i] ? W'(i) : upper_idx_s;
            any_idx_s   = valid[i]   ? W'(i) : any_idx_s;
        end
        found = |valid;
        idx   = (|upper_s) ? upper_idx_s : any_idx_s;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one uart byte channel.
// Define UART_ARB_TAG_EN to prefix every packet with an ASCII client tag byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  GAP_MAX = 65535,
    localparam int GRANT_W = grant_w(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   enable_tx,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   busy
);

    // The counter only needs to hold 0..GAP_MAX-1; release fires on the last value.
    localparam int                 GAP_W    = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_MAX - 1);
    localparam logic [GRANT_W-1:0] LAST_ID  = GRANT_W'(NUM_REQ - 1);

    state_t               state_r;
    logic [GRANT_W-1:0]   grant_r;
    logic [GRANT_W-1:0]   ptr_r;
    logic [7:0]           tx_data_r;
    logic                 enable_tx_r;
    logic                 last_r;
    logic                 busy_r;
    logic [NUM_REQ-1:0]   req_ready_r;
    logic [GAP_W-1:0]     gap_cnt_r;

    logic                 pick_found_s;
    logic [GRANT_W-1:0]   pick_idx_s;
    logic                 grant_valid_s;
    logic                 grant_last_s;
    logic [7:0]           grant_data_s;
    logic [GRANT_W-1:0]   next_ptr_s;

    uart_rr_pick #(
        .N (NUM_REQ),
        .W (GRANT_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign grant_valid_s = req_valid[grant_r];
    assign grant_last_s  = req_last[grant_r];
    assign grant_data_s  = req_data[{grant_r, 3'b000} +: 8];
    // Finished (or evicted) client drops to lowest priority.
    assign next_ptr_s    = (grant_r == LAST_ID) ? {GRANT_W{1'b0}} : grant_r + GRANT_W'(1'b1);

    // Arbitration, packet lock, byte hand-off to the uart and gap watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            grant_r     <= {GRANT_W{1'b0}};
            ptr_r       <= {GRANT_W{1'b0}};
            tx_data_r   <= 8'h00;
            enable_tx_r <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= {NUM_REQ{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
        end else begin
            enable_tx_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (pick_found_s) begin
                        grant_r <= pick_idx_s;
                        busy_r  <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        tx_data_r   <= TAG_BASE + 8'(pick_idx_s);
                        enable_tx_r <= 1'b1;
                        state_r     <= S_TAG;
`else
                        req_ready_r <= NUM_REQ'(1'b1) << pick_idx_s;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                        state_r     <= S_SEND;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
`ifdef UART_ARB_TAG_EN
                S_TAG: begin
                    if (tx_done) begin
                        req_ready_r <= NUM_REQ'(1'b1) << grant_r;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                        state_r     <= S_SEND;
                    end else begin
                        state_r <= S_TAG;
                    end
                end
`endif
                S_SEND: begin
                    if (grant_valid_s) begin
                        tx_data_r   <= grant_data_s;
                        last_r      <= grant_last_s;
                        enable_tx_r <= 1'b1;
                        req_ready_r <= {NUM_REQ{1'b0}};
                        state_r     <= S_WAIT;
                    end else if (gap_cnt_r == GAP_LAST) begin
                        req_ready_r <= {NUM_REQ{1'b0}};
                        ptr_r       <= next_ptr_s;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                    end
                end
                S_WAIT: begin
                    if (tx_done && last_r) begin
                        ptr_r   <= next_ptr_s;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (tx_done) begin
                        req_ready_r <= NUM_REQ'(1'b1) << grant_r;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                        state_r     <= S_SEND;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                default: begin
                    req_ready_r <= {NUM_REQ{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign enable_tx = enable_tx_r;
    assign tx_data   = tx_data_r;
    assign grant_id  = grant_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single client, round-robin wrap,
// gap watchdog, stray tx_done, async reset and (with UART_ARB_TAG_EN) tag bytes.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP_MAX = 20;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        enable_tx;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;

    int chk_cnt = 0;
    int err_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GAP_MAX (GAP_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .enable_tx (enable_tx),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h0000_0000;
        tx_done   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, " enable_tx"}, 32'(enable_tx), 32'd0);
        check_eq({tag, " tx_data"},   32'(tx_data),   32'h00);
        check_eq({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, " grant_id"},  32'(grant_id),  32'd0);
        check_eq({tag, " busy"},      32'(busy),      32'd0);
        rst_n = 1'b1;
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic serve_tag(input int c, input int delay, input string tag);
        int to;
        to = 0;
        while (enable_tx !== 1'b1 && to < 300) begin
            @(negedge clk);
            to++;
        end
        check_eq({tag, " tag pulse"}, 32'(enable_tx), 32'd1);
        check_eq({tag, " tag byte"},  32'(tx_data),   32'h30 + 32'(c));
        check_eq({tag, " tag ready"}, 32'(req_ready), 32'd0);
        repeat (delay) @(negedge clk);
        check_eq({tag, " tag hold"},  32'(req_ready), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq({tag, " ready after tag"}, 32'(req_ready[c]), 32'd1);
    endtask
`endif

    // Client c offers n bytes (byte i = pkt[i*8 +: 8]); close marks the final byte last.
    task automatic send_packet(input int c, input logic [31:0] pkt, input int n,
                               input logic close, input int delay, input string tag);
        int to;
        req_valid[c]       = 1'b1;
        req_data[c*8 +: 8] = pkt[7:0];
        req_last[c]        = close && (n == 1);
`ifdef UART_ARB_TAG_EN
        serve_tag(c, delay, tag);
`endif
        for (int i = 0; i < n; i++) begin
            to = 0;
            while (req_ready[c] !== 1'b1 && to < 300) begin
                @(negedge clk);
                to++;
            end
            check_eq({tag, " ready"}, 32'(req_ready[c]), 32'd1);
            check_eq({tag, " grant"}, 32'(grant_id), 32'(c));
            @(negedge clk);
            check_eq({tag, " enable"},    32'(enable_tx), 32'd1);
            check_eq({tag, " data"},      32'(tx_data),   32'(pkt[i*8 +: 8]));
            check_eq({tag, " ready low"}, 32'(req_ready), 32'd0);
            if (i + 1 < n) begin
                req_data[c*8 +: 8] = pkt[(i+1)*8 +: 8];
                req_last[c]        = close && (i + 2 == n);
            end else begin
                req_valid[c] = 1'b0;
                req_last[c]  = 1'b0;
            end
            @(negedge clk);
            check_eq({tag, " pulse width"}, 32'(enable_tx), 32'd0);
            repeat (delay - 2) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (i + 1 < n || !close) begin
                check_eq({tag, " ready after done"}, 32'(req_ready[c]), 32'd1);
            end else begin
                check_eq({tag, " idle after last"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int cnt;
        int to;
        logic saw_en;

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h0000_0000;
        tx_done   = 1'b0;

        // 1: client 2 alone sends "Hi\n"
        do_reset("rst1");
        send_packet(2, 32'h000A_6948, 3, 1'b1, 100, "t1");

        // 2: clients 0,1,3 valid from reset; order 0,1,3,0
        do_reset("rst2");
        req_valid[1] = 1'b1; req_data[15:8]  = 8'hB0; req_last[1] = 1'b0;
        req_valid[3] = 1'b1; req_data[31:24] = 8'hD0; req_last[3] = 1'b0;
        send_packet(0, 32'h0000_A1A0, 2, 1'b1, 4, "t2a");
        req_valid[0] = 1'b1; req_data[7:0] = 8'hC0; req_last[0] = 1'b0;
        send_packet(1, 32'h0000_B1B0, 2, 1'b1, 4, "t2b");
        send_packet(3, 32'h0000_D1D0, 2, 1'b1, 4, "t2c");
        send_packet(0, 32'h0000_C1C0, 2, 1'b1, 4, "t2d");

        // 3: client 1 stalls mid-packet; watchdog frees the channel, client 2 next
        req_valid[0] = 1'b1; req_data[7:0]   = 8'h0F; req_last[0] = 1'b1;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h77; req_last[2] = 1'b1;
        send_packet(1, 32'h0000_0055, 1, 1'b0, 4, "t3");
        cnt    = 0;
        saw_en = 1'b0;
        while (req_ready[1] === 1'b1 && cnt < GAP_MAX + 5) begin
            if (enable_tx === 1'b1) saw_en = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check_eq("t3 gap cycles",   32'(cnt),    32'(GAP_MAX));
        check_eq("t3 no byte",      32'(saw_en), 32'd0);
        check_eq("t3 released",     32'(busy),   32'd0);
        send_packet(2, 32'h0000_0077, 1, 1'b1, 4, "t3b");

        // 4: stray tx_done in S_IDLE and in S_SEND is ignored
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("t4 idle busy",   32'(busy),      32'd0);
        check_eq("t4 idle enable", 32'(enable_tx), 32'd0);
        req_valid[3] = 1'b1; req_data[31:24] = 8'h99; req_last[3] = 1'b1;
`ifdef UART_ARB_TAG_EN
        serve_tag(3, 3, "t4tag");
`endif
        to = 0;
        while (req_ready[3] !== 1'b1 && to < 300) begin
            @(negedge clk);
            to++;
        end
        check_eq("t4 send ready", 32'(req_ready[3]), 32'd1);
        req_valid[3] = 1'b0;
        tx_done      = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("t4 send held",   32'(req_ready), 32'b1000);
        check_eq("t4 send enable", 32'(enable_tx), 32'd0);
        check_eq("t4 send busy",   32'(busy),      32'd1);
        req_valid[3] = 1'b1;
        @(negedge clk);
        check_eq("t4 byte enable", 32'(enable_tx), 32'd1);
        check_eq("t4 byte data",   32'(tx_data),   32'h99);
        req_valid[3] = 1'b0; req_last[3] = 1'b0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("t4 done idle", 32'(busy), 32'd0);

        // 5: reset mid-byte; pointer restarts at client 0
        send_packet(1, 32'h0000_0011, 1, 1'b1, 4, "t5a");
        req_valid[2] = 1'b1; req_data[23:16] = 8'h22; req_last[2] = 1'b1;
        to = 0;
        while (enable_tx !== 1'b1 && to < 300) begin
            @(negedge clk);
            to++;
        end
        check_eq("t5 enable seen", 32'(enable_tx), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5 async enable", 32'(enable_tx), 32'd0);
        check_eq("t5 async data",   32'(tx_data),   32'h00);
        check_eq("t5 async ready",  32'(req_ready), 32'd0);
        check_eq("t5 async grant",  32'(grant_id),  32'd0);
        check_eq("t5 async busy",   32'(busy),      32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid[2] = 1'b1; req_data[23:16] = 8'h22; req_last[2] = 1'b1;
        send_packet(0, 32'h0000_0001, 1, 1'b1, 4, "t5b");
        send_packet(2, 32'h0000_0022, 1, 1'b1, 4, "t5c");

        // 6: client 3 sends 'A' (tag '3' precedes it when tags are enabled)
        send_packet(3, 32'h0000_0041, 1, 1'b1, 5, "t6");

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
